led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
- Avalon-MM master that drives the 8-bit LED PIO slave (s1: 2-bit address, chipselect, write_n, 32-bit writedata) autonomously.
- Generates timed LED animations (rotate, bounce, blink, count) and writes each new pattern to PIO register 0 at a programmable tick rate.
- Sits in the system next to the PIO, on the same clock, so LED activity needs no CPU.

Parameters:
- TIMER_W, 24, width of the period input and the tick prescaler counter.
- RESET_PATTERN, 8'h01, value loaded into the pattern register at reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  level; 1 = run the animation, 0 = stop after any write in flight
- mode  in  2  00 rotate-left, 01 bounce, 10 blink, 11 binary count
- period  in  TIMER_W  clk cycles between pattern updates; 0 is treated as 1
- load_pattern  in  1  single-cycle pulse; load seed into the pattern register and write it out
- seed  in  8  pattern value used by load_pattern and by blink wrap detection
- avm_address  out  2  PIO register address; always 0
- avm_chipselect  out  1  PIO chipselect
- avm_write_n  out  1  PIO write strobe, active-low
- avm_writedata  out  32  {24'b0, pattern}
- avm_waitrequest  in  1  interconnect stall; tie to 0 for a direct PIO connection
- pattern  out  8  current pattern register, which mirrors the LEDs once the write completes
- busy  out  1  1 in every state except IDLE
- wrap_pulse  out  1  one-cycle pulse when an animation cycle completes

Behaviour:
- Clocking and reset: everything is on the rising edge of clk. reset is synchronous, active-high, and overrides all other inputs.
- Reset values:
  - State: IDLE.
  - pattern = RESET_PATTERN; dir = left; prescaler cnt = 0; pending_load = 0.
  - Outputs: avm_chipselect = 0, avm_write_n = 1, avm_address = 0, avm_writedata = 0, busy = 0, wrap_pulse = 0.
- FSM states: IDLE, WAIT_TICK, WRITE.
  - IDLE: bus idle. If load_pattern is high, pattern <= seed. If enable is high, go to WRITE next cycle, so the current pattern is output 1 cycle after enable. If both occur in the same cycle, the seed is written.
  - WAIT_TICK: cnt increments each cycle. Tick occurs when cnt == max(period,1)-1.
    - On tick: cnt <= 0, pattern <= next(pattern), go to WRITE.
    - load_pattern in WAIT_TICK: pattern <= seed, cnt <= 0, go to WRITE (this beats a simultaneous tick).
    - enable low in WAIT_TICK: go to IDLE, cnt <= 0.
  - WRITE: chipselect = 1, write_n = 0, address = 0, writedata = {24'b0, pattern}, all registered and held while avm_waitrequest = 1.
    - The cycle with waitrequest = 0 completes the write. Next state is WAIT_TICK if enable is high, otherwise IDLE. cnt <= 0.
    - load_pattern during WRITE sets pending_load (seed is captured then). On completion: pattern <= captured seed, then WRITE again if enable is high.
- Output timing: bus outputs are registered and deassert in the cycle after the write completes. Minimum spacing between writes is max(period,1)+1 cycles.
- next(pattern), with mode sampled at each update:
  - 00: rotate left {p[6:0], p[7]}. wrap_pulse when p[7] == 1.
  - 01: if dir = left and p[7] = 1, dir <= right and shift right; if dir = right and p[0] = 1, dir <= left and shift left; otherwise shift in dir with zero fill. wrap_pulse on each direction flip. A pattern of 0 stays 0 with no flip.
  - 10: ~p. wrap_pulse when the result equals seed.
  - 11: p + 1 mod 256. wrap_pulse on the 8'hFF -> 8'h00 step.
- Mode change mid-run: takes effect at the next tick. dir is kept across mode changes.
- wrap_pulse asserts in the cycle the new pattern is registered.

Decomposition:
- Shared package:
  - mode encodings (MODE_ROTATE, MODE_BOUNCE, MODE_BLINK, MODE_COUNT);
  - FSM state encoding;
  - PIO_DATA_ADDR = 2'd0.
- Sub-module led_pattern_next: combinational next-pattern, next-dir and wrap logic.
- Prescaler and FSM stay in the top module.

Test Plan:
- Reset, then enable=1, mode=00, period=4, waitrequest=0 -> write of 0x01 at cycle 1. Then writes of 0x02, 0x04, … every 5 cycles. wrap_pulse on the update 0x80 -> 0x01.
- mode=01, seed=0x40 loaded in IDLE, period=1 -> written sequence 0x40, 0x80, 0x40, 0x20. wrap_pulse at the 0x80 -> 0x40 flip.
- mode=11, load seed=0xFE, period=2 -> writes 0xFE, 0xFF, 0x00. wrap_pulse only on the 0x00 update. writedata upper 24 bits always 0.
- avm_waitrequest held high for 3 cycles during a write -> chipselect, write_n and writedata stable for 4 cycles. No tick is counted during the stall. load_pattern pulsed mid-stall is written next.
- enable dropped during WRITE -> the write completes, then IDLE with busy = 0 and the bus idle. period=0 behaves exactly as period=1.
- reset asserted in WAIT_TICK and again in WRITE -> next cycle chipselect = 0, write_n = 1, pattern = 0x01, state IDLE.

Source files
------------

// File: rtl/led_pattern_sequencer_pkg.sv
// rtl/led_pattern_sequencer_pkg.sv - shared encodings for the LED pattern sequencer
package led_pattern_sequencer_pkg;

  // Animation selected by the mode input
  typedef enum logic [1:0] {
    MODE_ROTATE = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_t;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_WRITE     = 2'd2
  } state_t;

  // PIO data register holding the LED value
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  // Bounce direction
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_pattern_next.sv
// rtl/led_pattern_next.sv - combinational next-pattern, next-direction and wrap logic
module led_pattern_next
  import led_pattern_sequencer_pkg::*;
(
  input  logic [1:0] i_mode,
  input  logic [7:0] i_pattern,
  input  logic       i_dir,
  input  logic [7:0] i_seed,
  output logic [7:0] o_pattern,
  output logic       o_dir,
  output logic       o_wrap
);

  // Compute the pattern that follows i_pattern for the selected animation
  always_comb begin
    o_pattern = i_pattern;
    o_dir     = i_dir;
    o_wrap    = 1'b0;
    case (i_mode)
      MODE_ROTATE: begin
        o_pattern = {i_pattern[6:0], i_pattern[7]};
        o_wrap    = i_pattern[7];
      end
      MODE_BOUNCE: begin
        if ((i_dir == DIR_LEFT) && i_pattern[7]) begin
          o_dir     = DIR_RIGHT;
          o_pattern = {1'b0, i_pattern[7:1]};
          o_wrap    = 1'b1;
        end else if ((i_dir == DIR_RIGHT) && i_pattern[0]) begin
          o_dir     = DIR_LEFT;
          o_pattern = {i_pattern[6:0], 1'b0};
          o_wrap    = 1'b1;
        end else if (i_dir == DIR_LEFT) begin
          o_pattern = {i_pattern[6:0], 1'b0};
        end else begin
          o_pattern = {1'b0, i_pattern[7:1]};
        end
      end
      MODE_BLINK: begin
        o_pattern = ~i_pattern;
        o_wrap    = ((~i_pattern) == i_seed);
      end
      MODE_COUNT: begin
        o_pattern = i_pattern + 8'd1;
        o_wrap    = (i_pattern == 8'hFF);
      end
      default: begin
        o_pattern = i_pattern;
      end
    endcase
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - autonomous Avalon-MM master animating the LED PIO
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int         TIMER_W       = 24,
  parameter logic [7:0] RESET_PATTERN = 8'h01
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [1:0]         i_mode,
  input  logic [TIMER_W-1:0] i_period,
  input  logic               i_load_pattern,
  input  logic [7:0]         i_seed,
  output logic [1:0]         o_avm_address,
  output logic               o_avm_chipselect,
  output logic               o_avm_write_n,
  output logic [31:0]        o_avm_writedata,
  input  logic               i_avm_waitrequest,
  output logic [7:0]         o_pattern,
  output logic               o_busy,
  output logic               o_wrap_pulse
);

  localparam logic [TIMER_W-1:0] CNT_ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

  state_t             r_state, w_state_nx;
  logic [7:0]         r_pattern, w_pattern_nx;
  logic               r_dir, w_dir_nx;
  logic [TIMER_W-1:0] r_cnt, w_cnt_nx;
  logic               r_pending, w_pending_nx;
  logic [7:0]         r_seed_cap, w_seed_cap_nx;
  logic               r_cs, w_cs_nx;
  logic               r_write_n, w_write_n_nx;
  logic [31:0]        r_writedata, w_writedata_nx;
  logic               r_wrap, w_wrap_nx;

  logic [TIMER_W-1:0] w_period_m1;
  logic               w_tick;
  logic [7:0]         w_next_pattern;
  logic               w_next_dir;
  logic               w_next_wrap;

  // A period of 0 runs at the same rate as a period of 1
  assign w_period_m1 = (i_period == '0) ? '0 : (i_period - CNT_ONE);
  assign w_tick      = (r_cnt == w_period_m1);

  led_pattern_next u_next (
    .i_mode    (i_mode),
    .i_pattern (r_pattern),
    .i_dir     (r_dir),
    .i_seed    (i_seed),
    .o_pattern (w_next_pattern),
    .o_dir     (w_next_dir),
    .o_wrap    (w_next_wrap)
  );

  // Next-state, datapath and registered bus-output decode
  always_comb begin
    w_state_nx    = r_state;
    w_pattern_nx  = r_pattern;
    w_dir_nx      = r_dir;
    w_cnt_nx      = r_cnt;
    w_pending_nx  = r_pending;
    w_seed_cap_nx = r_seed_cap;
    w_wrap_nx     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_load_pattern) w_pattern_nx = i_seed;
        if (i_enable) w_state_nx = ST_WRITE;
      end
      ST_WAIT_TICK: begin
        if (i_load_pattern) begin
          w_pattern_nx = i_seed;
          w_cnt_nx     = '0;
          w_state_nx   = i_enable ? ST_WRITE : ST_IDLE;
        end else if (!i_enable) begin
          w_cnt_nx   = '0;
          w_state_nx = ST_IDLE;
        end else if (w_tick) begin
          w_cnt_nx     = '0;
          w_pattern_nx = w_next_pattern;
          w_dir_nx     = w_next_dir;
          w_wrap_nx    = w_next_wrap;
          w_state_nx   = ST_WRITE;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      ST_WRITE: begin
        if (i_load_pattern) begin
          w_pending_nx  = 1'b1;
          w_seed_cap_nx = i_seed;
        end
        if (!i_avm_waitrequest) begin
          w_cnt_nx     = '0;
          w_pending_nx = 1'b0;
          if (r_pending || i_load_pattern) begin
            // A seed loaded during this write goes straight out next
            w_pattern_nx = i_load_pattern ? i_seed : r_seed_cap;
            w_state_nx   = i_enable ? ST_WRITE : ST_IDLE;
          end else begin
            w_state_nx   = i_enable ? ST_WAIT_TICK : ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
    w_cs_nx        = (w_state_nx == ST_WRITE);
    w_write_n_nx   = !w_cs_nx;
    w_writedata_nx = w_cs_nx ? {24'b0, w_pattern_nx} : 32'b0;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_pattern   <= RESET_PATTERN;
      r_dir       <= DIR_LEFT;
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_seed_cap  <= 8'h00;
      r_cs        <= 1'b0;
      r_write_n   <= 1'b1;
      r_writedata <= 32'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_pattern   <= w_pattern_nx;
      r_dir       <= w_dir_nx;
      r_cnt       <= w_cnt_nx;
      r_pending   <= w_pending_nx;
      r_seed_cap  <= w_seed_cap_nx;
      r_cs        <= w_cs_nx;
      r_write_n   <= w_write_n_nx;
      r_writedata <= w_writedata_nx;
      r_wrap      <= w_wrap_nx;
    end
  end

  assign o_avm_address    = PIO_DATA_ADDR;
  assign o_avm_chipselect = r_cs;
  assign o_avm_write_n    = r_write_n;
  assign o_avm_writedata  = r_writedata;
  assign o_pattern        = r_pattern;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_wrap_pulse     = r_wrap;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - scoreboard bench for the LED pattern sequencer
module tb_led_pattern_sequencer;

  typedef struct {
    logic [7:0] data;
    int         at;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] period;
  logic        load;
  logic [7:0]  seed;
  logic        wreq;
  logic [1:0]  addr;
  logic        cs;
  logic        wn;
  logic [31:0] data;
  logic [7:0]  pat;
  logic        busy;
  logic        wrap;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  wr_t        exp_q[$];
  logic [7:0] wrap_q[$];
  wr_t        mon_e;

  led_pattern_sequencer #(.TIMER_W(24), .RESET_PATTERN(8'h01)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_enable          (en),
    .i_mode            (mode),
    .i_period          (period),
    .i_load_pattern    (load),
    .i_seed            (seed),
    .o_avm_address     (addr),
    .o_avm_chipselect  (cs),
    .o_avm_write_n     (wn),
    .o_avm_writedata   (data),
    .i_avm_waitrequest (wreq),
    .o_pattern         (pat),
    .o_busy            (busy),
    .o_wrap_pulse      (wrap)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp bus writes
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Bus and wrap monitor: pops the scoreboard on each completed write and wrap pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (cs && !wn && !wreq) begin
        check("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("wr_addr", addr, 0);
          check("wr_upper", data[31:8], 0);
          check("wr_data", data[7:0], mon_e.data);
          if (mon_e.at != 0) check("wr_cycle", cyc, mon_e.at);
        end
      end
      if (wrap) begin
        check("wrap_expected", wrap_q.size() != 0, 1);
        if (wrap_q.size() != 0) check("wrap_pat", pat, wrap_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_wr(input logic [7:0] d, input int at);
    wr_t e;
    e.data = d;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic drain(input int budget);
    wait_empty(budget);
    en = 1'b0;
    step();
    step();
    check("wrap_left", wrap_q.size(), 0);
    wrap_q.delete();
    check("idle_busy", busy, 0);
    check("idle_cs", cs, 0);
  endtask

  initial begin
    int base;
    logic [7:0] p;
    rst = 1'b1; en = 1'b0; mode = 2'b00; period = 24'd4;
    load = 1'b0; seed = 8'h00; wreq = 1'b0;
    step();
    step();
    check("rst_cs", cs, 0);
    check("rst_wn", wn, 1);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_wrap", wrap, 0);
    check("rst_pat", pat, 8'h01);
    rst = 1'b0;
    step();

    // Rotate, period 4: first write one cycle after enable, then every 5
    mode = 2'b00; period = 24'd4; en = 1'b1; base = cyc;
    p = 8'h01;
    for (int i = 0; i < 10; i++) begin
      push_wr(p, base + 1 + 5 * i);
      p = {p[6:0], p[7]};
    end
    wrap_q.push_back(8'h01);
    drain(200);

    // Bounce from seed 0x40, period 1
    mode = 2'b01; period = 24'd1; seed = 8'h40; load = 1'b1;
    step();
    load = 1'b0;
    check("t2_load_pat", pat, 8'h40);
    check("t2_load_busy", busy, 0);
    en = 1'b1; base = cyc;
    push_wr(8'h40, base + 1);
    push_wr(8'h80, base + 3);
    push_wr(8'h40, base + 5);
    push_wr(8'h20, base + 7);
    wrap_q.push_back(8'h40);
    drain(50);

    // Count from 0xFE, period 2, load and enable together
    mode = 2'b11; period = 24'd2; seed = 8'hFE; load = 1'b1; en = 1'b1; base = cyc;
    push_wr(8'hFE, base + 1);
    push_wr(8'hFF, base + 4);
    push_wr(8'h00, base + 7);
    wrap_q.push_back(8'h00);
    step();
    load = 1'b0;
    drain(50);

    // Blink from seed 0x0F, period 1
    mode = 2'b10; period = 24'd1; seed = 8'h0F; load = 1'b1; en = 1'b1; base = cyc;
    push_wr(8'h0F, base + 1);
    push_wr(8'hF0, base + 3);
    push_wr(8'h0F, base + 5);
    push_wr(8'hF0, base + 7);
    wrap_q.push_back(8'h0F);
    step();
    load = 1'b0;
    drain(50);

    // Three-cycle stall with a load mid-stall, then rotate at period 3
    mode = 2'b00; period = 24'd3; wreq = 1'b1; seed = 8'h33; load = 1'b1; en = 1'b1; base = cyc;
    push_wr(8'h33, base + 4);
    push_wr(8'h5A, base + 5);
    push_wr(8'hB4, base + 9);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("stall_cs", cs, 1);
      check("stall_wn", wn, 0);
      check("stall_data", data, 32'h33);
      load = (i == 2);
      if (i == 2) seed = 8'h5A;
      if (i == 4) wreq = 1'b0;
    end
    drain(50);

    // Enable dropped mid-write: write completes, then idle
    mode = 2'b00; period = 24'd0; wreq = 1'b1; seed = 8'h03; load = 1'b1; en = 1'b1;
    push_wr(8'h03, 0);
    step();
    load = 1'b0; en = 1'b0;
    step();
    wreq = 1'b0;
    step();
    check("t5_busy", busy, 0);
    check("t5_cs", cs, 0);
    check("t5_wn", wn, 1);
    check("t5_data", data, 0);
    check("t5_pat", pat, 8'h03);
    check("t5_written", exp_q.size(), 0);
    exp_q.delete();

    // Period 0 spaces writes exactly like period 1
    en = 1'b1; base = cyc;
    push_wr(8'h03, base + 1);
    push_wr(8'h06, base + 3);
    push_wr(8'h0C, base + 5);
    drain(50);

    // Reset in WAIT_TICK, then in WRITE
    period = 24'd8; en = 1'b1; base = cyc;
    push_wr(8'h0C, base + 1);
    wait_empty(20);
    check("t6_busy_wait", busy, 1);
    rst = 1'b1;
    step();
    check("t6a_cs", cs, 0);
    check("t6a_wn", wn, 1);
    check("t6a_pat", pat, 8'h01);
    check("t6a_busy", busy, 0);
    rst = 1'b0; wreq = 1'b1;
    step();
    check("t6_write_cs", cs, 1);
    check("t6_write_data", data, 32'h01);
    rst = 1'b1;
    step();
    check("t6b_cs", cs, 0);
    check("t6b_wn", wn, 1);
    check("t6b_pat", pat, 8'h01);
    check("t6b_busy", busy, 0);
    check("t6b_data", data, 0);
    rst = 1'b0; en = 1'b0; wreq = 1'b0;
    step();
    step();
    check("t6_end_cs", cs, 0);
    check("t6_end_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
